alu_multicycle: RTL



---
 rtl/alu_multicycle.sv | 129 ++++++++++++
 1 files changed

// File: rtl/alu_multicycle.sv
// alu_multicycle: registered multi-cycle ALU with a START/BUSY/DONE handshake.
// Define ALU_MUL_EN to build the iterative shift-add multiplier on opcode 111.
module alu_multicycle #(
   parameter int WIDTH = 8,
   localparam int SHW = $clog2(WIDTH)
) (
   input  logic             CLK,
   input  logic             RESET,
   input  logic             START,
   input  logic [WIDTH-1:0] DATA1,
   input  logic [WIDTH-1:0] DATA2,
   input  logic [2:0]       SELECT,
   output logic [WIDTH-1:0] RESULT,
   output logic             ZERO,
   output logic             BUSY,
   output logic             DONE,
   output logic             ILLEGAL
);

   typedef enum logic [1:0] {IDLE, EXEC, FINISH} state_t;

   localparam logic [2:0] OP_FWD = 3'b000;
   localparam logic [2:0] OP_ADD = 3'b001;
   localparam logic [2:0] OP_AND = 3'b010;
   localparam logic [2:0] OP_OR  = 3'b011;
   localparam logic [2:0] OP_SUB = 3'b100;
   localparam logic [2:0] OP_SLL = 3'b101;
   localparam logic [2:0] OP_SRA = 3'b110;
`ifdef ALU_MUL_EN
   localparam logic [2:0] OP_MUL = 3'b111;
`endif

   state_t           state;
   logic [2:0]       op;
   logic [WIDTH-1:0] a;
   logic [WIDTH-1:0] b;
   logic [WIDTH-1:0] acc;
   logic [SHW:0]     cnt;

   assign ZERO = ~|RESULT;

   always_ff @(posedge CLK) begin
      if (RESET) begin
         state   <= IDLE;
         op      <= '0;
         a       <= '0;
         b       <= '0;
         acc     <= '0;
         cnt     <= '0;
         RESULT  <= '0;
         BUSY    <= 1'b0;
         DONE    <= 1'b0;
         ILLEGAL <= 1'b0;
      end else begin
         DONE    <= 1'b0;
         ILLEGAL <= 1'b0;
         unique case (state)
            IDLE: begin
               if (START) begin
                  a     <= DATA1;
                  b     <= DATA2;
                  op    <= SELECT;
                  acc   <= DATA1;
                  cnt   <= {1'b0, DATA2[SHW-1:0]};
                  BUSY  <= 1'b1;
                  state <= EXEC;
`ifdef ALU_MUL_EN
                  // multiplier runs one step per operand bit
                  if (SELECT == OP_MUL) begin
                     acc <= '0;
                     cnt <= (SHW+1)'(WIDTH);
                  end
`endif
               end
            end
            EXEC: begin
               state <= FINISH;
               unique case (op)
                  OP_FWD: acc <= b;
                  OP_ADD: acc <= a + b;
                  OP_AND: acc <= a & b;
                  OP_OR:  acc <= a | b;
                  OP_SUB: acc <= a + ~b + 1'b1;
                  OP_SLL: begin
                     if (cnt != '0) begin
                        acc   <= {acc[WIDTH-2:0], 1'b0};
                        cnt   <= cnt - 1'b1;
                        state <= EXEC;
                     end
                  end
                  OP_SRA: begin
                     if (cnt != '0) begin
                        acc   <= {acc[WIDTH-1], acc[WIDTH-1:1]};
                        cnt   <= cnt - 1'b1;
                        state <= EXEC;
                     end
                  end
`ifdef ALU_MUL_EN
                  OP_MUL: begin
                     if (cnt != '0) begin
                        if (b[0]) acc <= acc + a;
                        a     <= {a[WIDTH-2:0], 1'b0};
                        b     <= {1'b0, b[WIDTH-1:1]};
                        cnt   <= cnt - 1'b1;
                        state <= EXEC;
                     end
                  end
`else
                  default: acc <= '0;
`endif
               endcase
            end
            FINISH: begin
               RESULT <= acc;
               DONE   <= 1'b1;
               BUSY   <= 1'b0;
               state  <= IDLE;
`ifdef ALU_MUL_EN
               ILLEGAL <= 1'b0;
`else
               ILLEGAL <= (op == 3'b111);
`endif
            end
            default: state <= IDLE;
         endcase
      end
   end

endmodule
